// File: rtl/regional_clk_divider.sv
// ----------------------------------------------------------------------------
// regional_clk_divider
//
// Purpose:
//   Receiving-end divider for one clock region. Divides the buffered fabric
//   clock by DIVIDE into a registered regional clock (div_o). It also emits
//   single-cycle rise/fall strobes for logic that cannot use div_o as a clock.
//   The divider advances only while the registered enable (r_ce_q) is high.
//   While the enable is low, the phase and div_o are frozen.
//
// Build option:
//   REGIONAL_CLK_DIVIDER_CE_SYNC_EN - when defined, ce_i passes through a
//   2-flop synchronizer (2-cycle enable latency). When undefined, ce_i passes
//   through a single register (1-cycle enable latency).
//
// Parameters:
//   DIVIDE   - division ratio, legal range 2..8.
//   HIGH_CNT - derived: clk cycles per period for which div_o is high.
//
// Ports:
//   clk      in   buffered source clock, rising edge
//   rst_n    in   synchronous reset, active-low
//   ce_i     in   clock enable (registered before use)
//   clr_i    in   synchronous phase clear, active-high
//   div_o    out  divided clock (registered)
//   rise_o   out  one-cycle pulse in the cycle div_o first reads 1
//   fall_o   out  one-cycle pulse in the cycle div_o first reads 0
//   active_o out  set by the first rise since reset/clear
//   cnt_o    out  phase counter (debug)
// ----------------------------------------------------------------------------
module regional_clk_divider #(
    parameter int unsigned DIVIDE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_i,
    input  logic       clr_i,
    output logic       div_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic       active_o,
    output logic [2:0] cnt_o
);

    localparam int unsigned HIGH_CNT = (DIVIDE + 1) / 2;
    localparam logic [2:0]  LAST_CNT = 3'(DIVIDE - 1);
    localparam logic [2:0]  HIGH_LIM = 3'(HIGH_CNT);

    if ((DIVIDE < 2) || (DIVIDE > 8)) begin : g_bad_divide
        $error("regional_clk_divider: DIVIDE must be in 2..8");
    end

    logic       r_ce_q;
    logic [2:0] r_cnt;
    logic       r_div;
    logic       r_rise;
    logic       r_fall;
    logic       r_active;
    logic [2:0] w_cnt_nxt;

    // Enable pipeline: only reset clears it; clr_i leaves it running.
`ifdef REGIONAL_CLK_DIVIDER_CE_SYNC_EN
    logic r_ce_s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ce_s1 <= 1'b0;
            r_ce_q  <= 1'b0;
        end else begin
            r_ce_s1 <= ce_i;
            r_ce_q  <= r_ce_s1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ce_q <= 1'b0;
        end else begin
            r_ce_q <= ce_i;
        end
    end
`endif

    always_comb begin
        w_cnt_nxt = (r_cnt == LAST_CNT) ? 3'd0 : r_cnt + 3'd1;
    end

    // Reset and clear both park the counter at LAST_CNT, so the first enabled
    // edge wraps to 0 and produces a clean rising edge plus a rise strobe.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            r_cnt    <= LAST_CNT;
            r_div    <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_active <= 1'b0;
        end else if (r_ce_q) begin
            r_cnt    <= w_cnt_nxt;
            r_div    <= (w_cnt_nxt < HIGH_LIM);
            r_rise   <= (w_cnt_nxt == 3'd0);
            r_fall   <= (w_cnt_nxt == HIGH_LIM);
            r_active <= r_active | (w_cnt_nxt == 3'd0);
        end else begin
            // Frozen: phase and div_o hold; strobes must not repeat.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end
    end

    assign div_o    = r_div;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign active_o = r_active;
    assign cnt_o    = r_cnt;

endmodule

// File: tb/tb_regional_clk_divider.sv
// ----------------------------------------------------------------------------
// tb_regional_clk_divider
//
// Three divider instances (DIVIDE = 4, 5, 2), each with its own reset/enable/
// clear. The stimulus process drives one instance per step on the falling
// edge. It pushes the hand-computed post-edge outputs
// {div, rise, fall, active, cnt} into a queue. The monitor samples 1 ns after
// each rising edge and checks the oldest queued entry against the targeted
// instance.
// ----------------------------------------------------------------------------
module tb_regional_clk_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_v [3];
    logic       ce_v    [3];
    logic       clr_v   [3];
    logic       div_v   [3];
    logic       rise_v  [3];
    logic       fall_v  [3];
    logic       act_v   [3];
    logic [2:0] cnt_v   [3];

    regional_clk_divider #(.DIVIDE(4)) u_div4 (
        .clk      (clk),
        .rst_n    (rst_n_v[0]),
        .ce_i     (ce_v[0]),
        .clr_i    (clr_v[0]),
        .div_o    (div_v[0]),
        .rise_o   (rise_v[0]),
        .fall_o   (fall_v[0]),
        .active_o (act_v[0]),
        .cnt_o    (cnt_v[0])
    );

    regional_clk_divider #(.DIVIDE(5)) u_div5 (
        .clk      (clk),
        .rst_n    (rst_n_v[1]),
        .ce_i     (ce_v[1]),
        .clr_i    (clr_v[1]),
        .div_o    (div_v[1]),
        .rise_o   (rise_v[1]),
        .fall_o   (fall_v[1]),
        .active_o (act_v[1]),
        .cnt_o    (cnt_v[1])
    );

    regional_clk_divider #(.DIVIDE(2)) u_div2 (
        .clk      (clk),
        .rst_n    (rst_n_v[2]),
        .ce_i     (ce_v[2]),
        .clr_i    (clr_v[2]),
        .div_o    (div_v[2]),
        .rise_o   (rise_v[2]),
        .fall_o   (fall_v[2]),
        .active_o (act_v[2]),
        .cnt_o    (cnt_v[2])
    );

    typedef struct {
        int         unit;
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: one queued expectation per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t       e;
                logic [6:0] act;
                e   = q.pop_front();
                act = {div_v[e.unit], rise_v[e.unit], fall_v[e.unit], act_v[e.unit],
                       cnt_v[e.unit]};
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got div/rise/fall/act/cnt=%b/%b/%b/%b/%0d, want %b/%b/%b/%b/%0d",
                             e.name, act[6], act[5], act[4], act[3], act[2:0],
                             e.exp[6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
                end
            end
        end
    end

    task automatic step(input int u, input logic rst, input logic clr, input logic ce,
                        input logic d, input logic r, input logic f, input logic a,
                        input int c, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n_v[u] = rst;
        clr_v[u]   = clr;
        ce_v[u]    = ce;
        e.unit = u;
        e.exp  = {d, r, f, a, 3'(c)};
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n_v[i] = 1'b0;
            ce_v[i]    = 1'b0;
            clr_v[i]   = 1'b0;
        end

`ifndef REGIONAL_CLK_DIVIDER_CE_SYNC_EN
        // DIVIDE=4 startup: rise on 2nd edge after release, pattern 1,1,0,0.
        //      u  rst clr ce   d  r  f  a  cnt
        step(0, 0, 0, 1,   0, 0, 0, 0, 3, "d4_reset0");
        step(0, 0, 0, 1,   0, 0, 0, 0, 3, "d4_reset1");
        step(0, 1, 0, 1,   0, 0, 0, 0, 3, "d4_rel_latency");
        step(0, 1, 0, 1,   1, 1, 0, 1, 0, "d4_first_rise");
        step(0, 1, 0, 1,   1, 0, 0, 1, 1, "d4_high2");
        step(0, 1, 0, 1,   0, 0, 1, 1, 2, "d4_fall");
        step(0, 1, 0, 1,   0, 0, 0, 1, 3, "d4_low2");
        step(0, 1, 0, 1,   1, 1, 0, 1, 0, "d4_rise2");
        step(0, 1, 0, 1,   1, 0, 0, 1, 1, "d4_high2b");
        step(0, 1, 0, 1,   0, 0, 1, 1, 2, "d4_fall2");
        step(0, 1, 0, 1,   0, 0, 0, 1, 3, "d4_low2b");
        step(0, 1, 0, 1,   1, 1, 0, 1, 0, "d4_rise3");
        // Drop ce_i for 3 cycles starting while cnt reaches 1: frozen high.
        step(0, 1, 0, 0,   1, 0, 0, 1, 1, "ce_drop_edge");
        step(0, 1, 0, 0,   1, 0, 0, 1, 1, "ce_frozen1");
        step(0, 1, 0, 0,   1, 0, 0, 1, 1, "ce_frozen2");
        step(0, 1, 0, 1,   1, 0, 0, 1, 1, "ce_frozen3");
        step(0, 1, 0, 1,   0, 0, 1, 1, 2, "ce_resume_fall");
        // Clear at cnt=2: back to reset values, ce pipeline keeps running.
        step(0, 1, 1, 1,   0, 0, 0, 0, 3, "clr_values");
        step(0, 1, 0, 1,   1, 1, 0, 1, 0, "clr_then_rise");
        step(0, 1, 0, 1,   1, 0, 0, 1, 1, "clr_then_high");
        // Reset and clear together, then release reset only.
        step(0, 0, 1, 1,   0, 0, 0, 0, 3, "rst_clr_both");
        step(0, 1, 0, 1,   0, 0, 0, 0, 3, "rst_rel_latency");
        step(0, 1, 0, 1,   1, 1, 0, 1, 0, "rst_rel_rise");
        step(0, 1, 0, 1,   1, 0, 0, 1, 1, "rst_rel_high");

        // DIVIDE=5: high 3, low 2, cnt 0..4.
        step(1, 0, 0, 1,   0, 0, 0, 0, 4, "d5_reset");
        step(1, 1, 0, 1,   0, 0, 0, 0, 4, "d5_rel_latency");
        step(1, 1, 0, 1,   1, 1, 0, 1, 0, "d5_c0");
        step(1, 1, 0, 1,   1, 0, 0, 1, 1, "d5_c1");
        step(1, 1, 0, 1,   1, 0, 0, 1, 2, "d5_c2");
        step(1, 1, 0, 1,   0, 0, 1, 1, 3, "d5_c3_fall");
        step(1, 1, 0, 1,   0, 0, 0, 1, 4, "d5_c4");
        step(1, 1, 0, 1,   1, 1, 0, 1, 0, "d5_wrap");
        step(1, 1, 0, 1,   1, 0, 0, 1, 1, "d5_c1b");
`endif

        // DIVIDE=2: strobes alternate every enabled cycle.
        step(2, 0, 0, 1,   0, 0, 0, 0, 1, "d2_reset");
        step(2, 1, 0, 1,   0, 0, 0, 0, 1, "d2_rel_latency");
`ifdef REGIONAL_CLK_DIVIDER_CE_SYNC_EN
        step(2, 1, 0, 1,   0, 0, 0, 0, 1, "d2_sync_latency");
`endif
        step(2, 1, 0, 1,   1, 1, 0, 1, 0, "d2_rise");
        step(2, 1, 0, 1,   0, 0, 1, 1, 1, "d2_fall");
        step(2, 1, 0, 1,   1, 1, 0, 1, 0, "d2_rise2");
        step(2, 1, 0, 1,   0, 0, 1, 1, 1, "d2_fall2");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
